// File: rtl/freq_ctrl_pkg.sv
// Shared types and default widths for the frequency-measurement sequencer.
package freq_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;  // edge-counter / result width
  localparam int unsigned GW_W_DEF  = 24;  // gate-length width in clk cycles
  localparam int unsigned SETTLE_W  = 3;   // settle counter width (SETTLE is 1..7)

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LATCH  = 3'd4
  } state_t;

endpackage : freq_ctrl_pkg

// File: rtl/freq_meas_ctrl_gate_timer.sv
// Loadable down-counter timing the gate window.
//   clk, rst : clock, synchronous active-high reset
//   load     : load len (0 is treated as 1)
//   en       : count down, one step per cycle
//   len      : window length in clk cycles
//   done_c   : combinational, high on the last enabled cycle of the window
module gate_timer #(
  parameter int unsigned GW_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [GW_W-1:0] len,
  output logic            done_c
);

  logic [GW_W-1:0] cnt;

  // Remaining window cycles, including the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (len == '0) ? GW_W'(1) : len;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - GW_W'(1);
    end
  end

  assign done_c = en && (cnt == GW_W'(1));

endmodule : gate_timer

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the edge-counting frequency counter: clears the
// counter, opens a gate window, waits to settle, latches the count.
//   clk, rst          : clock, synchronous active-high reset
//   start, cont, stop : run control (start/cont sampled in IDLE)
//   gate_len          : gate window length, sampled in CLEAR
//   cnt_in            : live edge-counter value
//   gate, cnt_clr     : controls to the edge counter
//   busy              : not IDLE
//   res_data, res_sat : latched count and all-ones flag
//   res_valid/ready   : result handshake
//   overrun           : sticky, unread result was overwritten
module freq_meas_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned GW_W   = GW_W_DEF,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  input  logic [GW_W-1:0]  gate_len,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             gate,
  output logic             cnt_clr,
  output logic             busy,
  output logic [CNT_W-1:0] res_data,
  output logic             res_sat,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun
);

  state_t              state, next_state;
  logic                cont_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                timer_done_c;
  logic                start_acc_c;

  assign start_acc_c = (state == ST_IDLE) && start && !stop;

  gate_timer #(.GW_W(GW_W)) u_gate_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ST_CLEAR),
    .en     (state == ST_GATE),
    .len    (gate_len),
    .done_c (timer_done_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_acc_c) next_state = ST_CLEAR;
      ST_CLEAR:  next_state = stop ? ST_IDLE : ST_GATE;
      ST_GATE: begin
        if (stop)              next_state = ST_IDLE;
        else if (timer_done_c) next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stop)                                         next_state = ST_IDLE;
        else if (settle_cnt == SETTLE_W'(SETTLE - 1)) next_state = ST_LATCH;
      end
      ST_LATCH:  next_state = (cont_q && !stop) ? ST_CLEAR : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Continuous-mode latch and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cont_q     <= 1'b0;
      settle_cnt <= '0;
    end else begin
      if (start_acc_c) cont_q <= cont;
      if (state == ST_SETTLE) settle_cnt <= settle_cnt + SETTLE_W'(1);
      else                    settle_cnt <= '0;
    end
  end

  // Counter controls registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      gate    <= 1'b0;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gate    <= (next_state == ST_GATE);
      cnt_clr <= (next_state == ST_CLEAR);
      busy    <= (next_state != ST_IDLE);
    end
  end

  // Result register, handshake and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data  <= '0;
      res_sat   <= 1'b0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (state == ST_LATCH) begin
      res_data  <= cnt_in;
      res_sat   <= (cnt_in == '1);
      res_valid <= 1'b1;
      // A same-cycle accept consumes the old result, so only a stalled one overruns
      if (res_valid && !res_ready) overrun <= 1'b1;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (start_acc_c)            overrun   <= 1'b0;
    end
  end

endmodule : freq_meas_ctrl
